befehl_laden: RTL and testbench
===============================

# befehl_laden

Instruction-fetch stage of the multicycle Hans processor, directly upstream of the `Steuerung` control FSM. It holds the program counter and fetches one instruction word from instruction memory when `LoadBefehlSignal` is asserted. It returns the word with a one-cycle `BefehlGeladen` pulse. It applies exactly one PC update per instruction, sequential or jump, when `PCSignal` is first asserted in writeback.

## Interface
- `ADRESS_BREITE`, 32: width of the PC and the memory address.
- `DATEN_BREITE`, 32: instruction word width.
- `START_ADRESSE`, 0: PC value after reset.
- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  reset, asynchronous and active-low; all state is cleared while it is low.
- `LoadBefehlSignal`  in  1  high while the control FSM is in FETCH.
- `PCSignal`  in  1  high during any writeback state; may stay high for several cycles.
- `PCSprungSignal`  in  1  jump taken; sampled only in the PC-update cycle.
- `SprungZiel`  in  ADRESS_BREITE  jump target from the ALU.
- `SpeicherLesen`  out  1  memory read request, registered.
- `SpeicherAdresse`  out  ADRESS_BREITE  read address, equal to PC while `SpeicherLesen` is high.
- `SpeicherBereit`  in  1  memory acknowledge; `SpeicherDaten` is valid in the same cycle.
- `SpeicherDaten`  in  DATEN_BREITE  read data.
- `Befehl`  out  DATEN_BREITE  last fetched instruction, held until the next capture.
- `BefehlGeladen`  out  1  one-cycle pulse: `Befehl` is valid.
- `PC`  out  ADRESS_BREITE  current PC.
- `NaechsterPC`  out  ADRESS_BREITE  PC+4, used for the JAL link value.

## Operation
- **FSM states:** LEERLAUF, ANFRAGE, FERTIG.
- **LEERLAUF:**
  - If `LoadBefehlSignal` is high, go to ANFRAGE, set `SpeicherLesen`=1 and latch `SpeicherAdresse`=PC.
  - If `PCSignal` is high in the same cycle, the PC update takes priority and the fetch starts the following cycle.
- **ANFRAGE:**
  - Hold the request until `SpeicherBereit`=1.
  - Then capture `SpeicherDaten` into `Befehl`, drop `SpeicherLesen`, pulse `BefehlGeladen` and go to FERTIG.
  - If `LoadBefehlSignal` has dropped meanwhile, the read still completes and `Befehl` is captured. The pulse is suppressed and the FSM returns to LEERLAUF.
- **FERTIG:** go to LEERLAUF once `LoadBefehlSignal`=0.
- **`SpeicherBereit` outside ANFRAGE:** ignored.
- **PC update guard:**
  - Flag `pc_aktualisiert` is cleared on entering ANFRAGE.
  - On the first cycle with `PCSignal`=1 and the flag clear:
    - PC <= `SprungZiel` with bits [1:0] cleared, if `PCSprungSignal`=1;
    - otherwise PC <= PC+4.
  - The flag is then set, so held `PCSignal` has no further effect.
- **Arithmetic:** PC+4 wraps modulo 2^ADRESS_BREITE; PC=max-3 gives 0.
- **Reset values:**
  - PC=`START_ADRESSE`, `NaechsterPC`=`START_ADRESSE`+4;
  - `Befehl`=0, `BefehlGeladen`=0, `SpeicherLesen`=0, `SpeicherAdresse`=0;
  - FSM=LEERLAUF, `pc_aktualisiert`=0.
- **Reset during ANFRAGE:** the request drops immediately and no data is captured.

## Timing
- All outputs are registered except `NaechsterPC`, which is combinational from PC.
- `LoadBefehlSignal` rises in cycle 0; `SpeicherLesen` is high from cycle 1.
- If `SpeicherBereit` is high in cycle k, `Befehl` and `BefehlGeladen` are valid in cycle k+1. Minimum fetch latency is 2 cycles.
- `BefehlGeladen` is high for exactly one cycle; `Steuerung` leaves FETCH on that edge.
- A PC update is visible one cycle after the first `PCSignal` cycle, before the next FETCH begins.

## Configuration
- Macro: `BEFEHL_AUSRICHTUNG_PRUEFUNG_EN`.
- **Defined:**
  - Extra port `Fehlausrichtung` (out, 1), reset 0.
  - It is set sticky when a taken jump has `SprungZiel[1:0]`≠0, and cleared only by reset.
  - The PC still loads the aligned target.
- **Undefined:** no port; the low bits are cleared silently.

## Structure
- Package `befehl_laden_pkg` holds:
  - the FSM state localparams (LEERLAUF, ANFRAGE, FERTIG);
  - `PC_SCHRITT`=4;
  - `BEFEHL_BREITE`.
- Sub-module `pc_register` holds the PC, the `pc_aktualisiert` guard, the increment/jump mux and the alignment check. The top level holds the fetch FSM and the memory handshake.

## Test plan
- Reset low, then high; raise `LoadBefehlSignal`; memory acks in cycle 1 with 0x00A00093 -> `SpeicherAdresse`=0, `Befehl`=0x00A00093, `BefehlGeladen` pulses in cycle 2 only.
- Ack delayed by 5 cycles -> `SpeicherLesen` is held for 5 cycles at a stable address; one pulse follows.
- `PCSignal` held 3 cycles with `PCSprungSignal`=0 from PC=0x10 -> PC=0x14, not 0x1C.
- Taken jump with `SprungZiel`=0x102:
  - PC=0x100;
  - with the macro, `Fehlausrichtung`=1 and it stays 1 across subsequent fetches.
- PC=0xFFFFFFFC, sequential update -> PC=0, `NaechsterPC`=4.
- Reset asserted during ANFRAGE -> `SpeicherLesen`=0 immediately, PC=`START_ADRESSE`, no `BefehlGeladen`.

Source files
------------

// File: rtl/befehl_laden_pkg.sv
// befehl_laden: shared constants for the Hans instruction-fetch stage.
// Optional build macro: BEFEHL_AUSRICHTUNG_PRUEFUNG_EN (jump alignment flag).
package befehl_laden_pkg;

  typedef logic [1:0] zustand_t;

  localparam zustand_t LEERLAUF = 2'd0;
  localparam zustand_t ANFRAGE  = 2'd1;
  localparam zustand_t FERTIG   = 2'd2;

  localparam int PC_SCHRITT    = 4;
  localparam int BEFEHL_BREITE = 32;

endpackage

// File: rtl/befehl_laden_pc_register.sv
// pc_register: program counter with one-update-per-instruction guard.
// BEFEHL_AUSRICHTUNG_PRUEFUNG_EN adds the sticky Fehlausrichtung flag.
module pc_register
  import befehl_laden_pkg::*;
#(
  parameter int                     ADRESS_BREITE = 32,
  parameter logic [ADRESS_BREITE-1:0] START_ADRESSE = '0
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     PCSignal,
  input  logic                     PCSprungSignal,
  input  logic [ADRESS_BREITE-1:0] SprungZiel,
  input  logic                     GuardLoeschen,
  output logic                     PCUpdate,
  output logic [ADRESS_BREITE-1:0] PC,
  output logic [ADRESS_BREITE-1:0] NaechsterPC
`ifdef BEFEHL_AUSRICHTUNG_PRUEFUNG_EN
  ,
  output logic                     Fehlausrichtung
`endif
);

  logic                     pcAktualisiert;
  logic [ADRESS_BREITE-1:0] sprungAusgerichtet;

  assign PCUpdate           = PCSignal && !pcAktualisiert;
  assign NaechsterPC        = PC + ADRESS_BREITE'(PC_SCHRITT);
  assign sprungAusgerichtet = SprungZiel & ~ADRESS_BREITE'(3);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      PC             <= START_ADRESSE;
      pcAktualisiert <= 1'b0;
    end else if (PCUpdate) begin
      PC             <= PCSprungSignal ? sprungAusgerichtet : NaechsterPC;
      pcAktualisiert <= 1'b1;
    end else if (GuardLoeschen) begin
      pcAktualisiert <= 1'b0;
    end
  end

`ifdef BEFEHL_AUSRICHTUNG_PRUEFUNG_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Fehlausrichtung <= 1'b0;
    end else if (PCUpdate && PCSprungSignal && (|SprungZiel[1:0])) begin
      Fehlausrichtung <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/befehl_laden.sv
// befehl_laden: fetch FSM and memory handshake of the Hans processor.
// BEFEHL_AUSRICHTUNG_PRUEFUNG_EN exposes the Fehlausrichtung port.
module befehl_laden
  import befehl_laden_pkg::*;
#(
  parameter int                     ADRESS_BREITE = 32,
  parameter int                     DATEN_BREITE  = BEFEHL_BREITE,
  parameter logic [ADRESS_BREITE-1:0] START_ADRESSE = '0
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     LoadBefehlSignal,
  input  logic                     PCSignal,
  input  logic                     PCSprungSignal,
  input  logic [ADRESS_BREITE-1:0] SprungZiel,
  output logic                     SpeicherLesen,
  output logic [ADRESS_BREITE-1:0] SpeicherAdresse,
  input  logic                     SpeicherBereit,
  input  logic [DATEN_BREITE-1:0]  SpeicherDaten,
  output logic [DATEN_BREITE-1:0]  Befehl,
  output logic                     BefehlGeladen,
  output logic [ADRESS_BREITE-1:0] PC,
  output logic [ADRESS_BREITE-1:0] NaechsterPC
`ifdef BEFEHL_AUSRICHTUNG_PRUEFUNG_EN
  ,
  output logic                     Fehlausrichtung
`endif
);

  zustand_t                 zustand;
  zustand_t                 zustandNaechst;
  logic                     pcUpdate;
  logic                     startAnfrage;
  logic                     lesenD;
  logic                     geladenD;
  logic [ADRESS_BREITE-1:0] adresseD;
  logic [DATEN_BREITE-1:0]  befehlD;

  pc_register #(
    .ADRESS_BREITE (ADRESS_BREITE),
    .START_ADRESSE (START_ADRESSE)
  ) pcReg (
    .Clock          (Clock),
    .Reset          (Reset),
    .PCSignal       (PCSignal),
    .PCSprungSignal (PCSprungSignal),
    .SprungZiel     (SprungZiel),
    .GuardLoeschen  (startAnfrage),
    .PCUpdate       (pcUpdate),
    .PC             (PC),
    .NaechsterPC    (NaechsterPC)
`ifdef BEFEHL_AUSRICHTUNG_PRUEFUNG_EN
    ,
    .Fehlausrichtung (Fehlausrichtung)
`endif
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      zustand         <= LEERLAUF;
      SpeicherLesen   <= 1'b0;
      SpeicherAdresse <= '0;
      Befehl          <= '0;
      BefehlGeladen   <= 1'b0;
    end else begin
      zustand         <= zustandNaechst;
      SpeicherLesen   <= lesenD;
      SpeicherAdresse <= adresseD;
      Befehl          <= befehlD;
      BefehlGeladen   <= geladenD;
    end
  end

  // a PC update in the same cycle defers the fetch by one cycle
  always_comb begin
    zustandNaechst = zustand;
    startAnfrage   = 1'b0;
    unique case (1'b1)
      (zustand == LEERLAUF): begin
        if (LoadBefehlSignal && !pcUpdate) begin
          startAnfrage   = 1'b1;
          zustandNaechst = ANFRAGE;
        end
      end
      (zustand == ANFRAGE): begin
        if (SpeicherBereit) begin
          zustandNaechst = LoadBefehlSignal ? FERTIG : LEERLAUF;
        end
      end
      (zustand == FERTIG): begin
        if (!LoadBefehlSignal) begin
          zustandNaechst = LEERLAUF;
        end
      end
      default: zustandNaechst = LEERLAUF;
    endcase
  end

  always_comb begin
    lesenD   = 1'b0;
    geladenD = 1'b0;
    adresseD = SpeicherAdresse;
    befehlD  = Befehl;
    if (startAnfrage) begin
      lesenD   = 1'b1;
      adresseD = PC;
    end
    if (zustand == ANFRAGE) begin
      if (SpeicherBereit) begin
        befehlD  = SpeicherDaten;
        geladenD = LoadBefehlSignal;
      end else begin
        lesenD = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_befehl_laden.sv
// tb_befehl_laden: vector table, corner sequences and random fetch/writeback
// traffic checked against a transaction-level PC model.
module tb_befehl_laden;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        LoadBefehlSignal;
  logic        PCSignal;
  logic        PCSprungSignal;
  logic [31:0] SprungZiel;
  logic        SpeicherLesen;
  logic [31:0] SpeicherAdresse;
  logic        SpeicherBereit;
  logic [31:0] SpeicherDaten;
  logic [31:0] Befehl;
  logic        BefehlGeladen;
  logic [31:0] PC;
  logic [31:0] NaechsterPC;
`ifdef BEFEHL_AUSRICHTUNG_PRUEFUNG_EN
  logic        Fehlausrichtung;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] curPC;
  logic        expMis;

  typedef struct {
    logic [31:0] daten;
    int          lat;
    logic        sprung;
    logic [31:0] ziel;
    int          hold;
    logic [31:0] pcErw;
  } vec_t;

  vec_t tab [7];

  befehl_laden dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .LoadBefehlSignal (LoadBefehlSignal),
    .PCSignal         (PCSignal),
    .PCSprungSignal   (PCSprungSignal),
    .SprungZiel       (SprungZiel),
    .SpeicherLesen    (SpeicherLesen),
    .SpeicherAdresse  (SpeicherAdresse),
    .SpeicherBereit   (SpeicherBereit),
    .SpeicherDaten    (SpeicherDaten),
    .Befehl           (Befehl),
    .BefehlGeladen    (BefehlGeladen),
    .PC               (PC),
    .NaechsterPC      (NaechsterPC)
`ifdef BEFEHL_AUSRICHTUNG_PRUEFUNG_EN
    ,
    .Fehlausrichtung  (Fehlausrichtung)
`endif
  );

  always #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chkMis();
`ifdef BEFEHL_AUSRICHTUNG_PRUEFUNG_EN
    chk("fehlausrichtung", Fehlausrichtung, expMis);
`endif
  endtask

  task automatic doFetch(input logic [31:0] d, input int lat);
    LoadBefehlSignal = 1'b1;
    tick();
    for (int i = 1; i <= lat; i++) begin
      chk("lesen_aktiv", SpeicherLesen, 1);
      chk("adresse", SpeicherAdresse, curPC);
      chk("geladen_frueh", BefehlGeladen, 0);
      SpeicherBereit = (i == lat);
      SpeicherDaten  = (i == lat) ? d : $urandom();
      tick();
    end
    SpeicherBereit = 1'b0;
    chk("befehl", Befehl, d);
    chk("geladen_puls", BefehlGeladen, 1);
    chk("lesen_ende", SpeicherLesen, 0);
    LoadBefehlSignal = 1'b0;
    tick();
    chk("geladen_einmal", BefehlGeladen, 0);
  endtask

  task automatic doWb(input logic j, input logic [31:0] t,
                      input int hold, input logic [31:0] e);
    for (int i = 0; i < hold; i++) begin
      PCSignal       = 1'b1;
      PCSprungSignal = (i == 0) ? j : 1'($urandom());
      SprungZiel     = (i == 0) ? t : $urandom();
      tick();
      if (i == 0) chk("pc_sofort", PC, e);
    end
    PCSignal       = 1'b0;
    PCSprungSignal = 1'b0;
    if (j && (t % 4 != 0)) expMis = 1'b1;
    tick();
    chk("pc", PC, e);
    chk("naechster_pc", NaechsterPC, e + 32'd4);
    chkMis();
    curPC = e;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] t;
    logic [31:0] e;
    logic        j;
    int          lat;
    int          hold;

    tab[0] = '{32'h00A00093, 1, 1'b0, 32'h0, 1, 32'h4};
    tab[1] = '{32'h12345678, 5, 1'b1, 32'h10, 2, 32'h10};
    tab[2] = '{32'hDEADBEEF, 2, 1'b0, 32'h0, 3, 32'h14};
    tab[3] = '{32'h00000013, 1, 1'b1, 32'h102, 1, 32'h100};
    tab[4] = '{32'hA5A5A5A5, 3, 1'b1, 32'hFFFFFFFC, 2, 32'hFFFFFFFC};
    tab[5] = '{32'h0F0F0F0F, 1, 1'b0, 32'h0, 1, 32'h0};
    tab[6] = '{32'h7E57C0DE, 2, 1'b1, 32'h7FFFFFFF, 1, 32'h7FFFFFFC};

    Reset            = 1'b0;
    LoadBefehlSignal = 1'b0;
    PCSignal         = 1'b0;
    PCSprungSignal   = 1'b0;
    SprungZiel       = '0;
    SpeicherBereit   = 1'b0;
    SpeicherDaten    = '0;
    expMis           = 1'b0;
    curPC            = 32'h0;
    tick();
    tick();
    chk("reset_pc", PC, 32'h0);
    chk("reset_naechster", NaechsterPC, 32'h4);
    chk("reset_befehl", Befehl, 32'h0);
    chk("reset_geladen", BefehlGeladen, 0);
    chk("reset_lesen", SpeicherLesen, 0);
    chk("reset_adresse", SpeicherAdresse, 32'h0);
    chkMis();
    Reset = 1'b1;
    tick();

    for (int r = 0; r < 7; r++) begin
      doFetch(tab[r].daten, tab[r].lat);
      doWb(tab[r].sprung, tab[r].ziel, tab[r].hold, tab[r].pcErw);
    end

    // fetch request and PC update arriving together
    doFetch(32'h11223344, 1);
    LoadBefehlSignal = 1'b1;
    PCSignal         = 1'b1;
    PCSprungSignal   = 1'b0;
    tick();
    chk("gleichzeitig_lesen", SpeicherLesen, 0);
    chk("gleichzeitig_pc", PC, curPC + 32'd4);
    PCSignal = 1'b0;
    curPC    = curPC + 32'd4;
    tick();
    chk("gleichzeitig_start", SpeicherLesen, 1);
    chk("gleichzeitig_adresse", SpeicherAdresse, curPC);
    SpeicherBereit = 1'b1;
    SpeicherDaten  = 32'hCAFEF00D;
    tick();
    SpeicherBereit = 1'b0;
    chk("gleichzeitig_befehl", Befehl, 32'hCAFEF00D);
    chk("gleichzeitig_puls", BefehlGeladen, 1);
    LoadBefehlSignal = 1'b0;
    tick();

    // fetch abandoned while the read is outstanding
    LoadBefehlSignal = 1'b1;
    tick();
    chk("abbruch_lesen", SpeicherLesen, 1);
    LoadBefehlSignal = 1'b0;
    tick();
    chk("abbruch_halten", SpeicherLesen, 1);
    SpeicherBereit = 1'b1;
    SpeicherDaten  = 32'h0BADC0DE;
    tick();
    chk("abbruch_befehl", Befehl, 32'h0BADC0DE);
    chk("abbruch_kein_puls", BefehlGeladen, 0);
    chk("abbruch_lesen_aus", SpeicherLesen, 0);
    SpeicherDaten = 32'h99999999;
    tick();
    SpeicherBereit = 1'b0;
    chk("bereit_ignoriert", Befehl, 32'h0BADC0DE);
    chk("bereit_kein_puls", BefehlGeladen, 0);
    chk("bereit_kein_lesen", SpeicherLesen, 0);

    for (int n = 0; n < 30; n++) begin
      d    = $urandom();
      lat  = $urandom_range(1, 4);
      j    = 1'($urandom_range(0, 1));
      t    = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC : $urandom();
      hold = $urandom_range(1, 4);
      e    = j ? (t - (t % 4)) : (curPC + 32'd4);
      doFetch(d, lat);
      doWb(j, t, hold, e);
    end

    // reset while a read is outstanding
    LoadBefehlSignal = 1'b1;
    tick();
    chk("rst_anfrage_lesen", SpeicherLesen, 1);
    Reset = 1'b0;
    #1;
    chk("rst_lesen_sofort", SpeicherLesen, 0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_geladen", BefehlGeladen, 0);
    SpeicherBereit = 1'b1;
    SpeicherDaten  = 32'h55555555;
    tick();
    tick();
    SpeicherBereit   = 1'b0;
    LoadBefehlSignal = 1'b0;
    Reset            = 1'b1;
    expMis           = 1'b0;
    curPC            = 32'h0;
    tick();
    chk("rst_befehl", Befehl, 32'h0);
    chk("rst_kein_puls", BefehlGeladen, 0);
    chk("rst_kein_lesen", SpeicherLesen, 0);
    chkMis();
    doFetch(32'h00100073, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
